iobank_sync: RTL



---
 rtl/iobank_sync_if.sv | 31 +++
 rtl/iobank_sync.sv | 94 +++++++++
 2 files changed

// File: rtl/iobank_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : iobank_sync_if
//  Purpose  : Control/status bundle between the GPIO mux and the pad bank.
//  Revision : 1.0  initial release
// ============================================================================
interface iobank_sync_if #(
    parameter int WIDTH  = 20,
    parameter int FILT_W = 4
);
    logic [WIDTH-1:0]  pad_o;
    logic [WIDTH-1:0]  pad_oe;
    logic [WIDTH-1:0]  pad_i;
    logic [FILT_W-1:0] filt_len;
    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;
    logic [WIDTH-1:0]  irq_clr;
    logic [WIDTH-1:0]  irq_pend;
    logic              irq;

    modport master (
        output pad_o, pad_oe, filt_len, rise_en, fall_en, irq_clr,
        input  pad_i, irq_pend, irq
    );

    modport slave (
        input  pad_o, pad_oe, filt_len, rise_en, fall_en, irq_clr,
        output pad_i, irq_pend, irq
    );
endinterface
`default_nettype wire

// File: rtl/iobank_sync.sv
`default_nettype none
// ============================================================================
//  Module   : iobank_sync
//  Purpose  : Registered tristate pad bank with synchronised, glitch-filtered
//             inputs and sticky per-pin edge interrupts.
//  Revision : 1.0  initial release
// ============================================================================
module iobank_sync #(
    parameter int WIDTH       = 20,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    iobank_sync_if.slave       bus,
    inout  wire  [WIDTH-1:0]   pads
);

    logic [WIDTH-1:0]  o_q;
    logic [WIDTH-1:0]  oe_q;
    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  filt_q;
    logic [WIDTH-1:0]  filt_d;
    logic [FILT_W-1:0] cnt_q [WIDTH];
    logic [FILT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]  irq_pend_q;
    logic [WIDTH-1:0]  irq_pend_d;
    logic [WIDTH-1:0]  w_sync;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_fall;

    // Driven straight from the async-reset flops so pads float as soon as rst rises.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign pads[i] = oe_q[i] ? o_q[i] : 1'bz;
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        w_rise = '0;
        w_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_sync[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= bus.filt_len) begin
                // >= lets a shortened filter length take effect immediately
                filt_d[i] = w_sync[i];
                cnt_d[i]  = '0;
                w_rise[i] = w_sync[i];
                w_fall[i] = ~w_sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + FILT_W'(1);
            end
        end
        irq_pend_d = (irq_pend_q & ~bus.irq_clr)
                   | (w_rise & bus.rise_en)
                   | (w_fall & bus.fall_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q        <= '0;
            oe_q       <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            filt_q     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            irq_pend_q <= '0;
        end else begin
            o_q        <= bus.pad_o;
            oe_q       <= bus.pad_oe;
            sync_q[0]  <= pads;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            filt_q     <= filt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            irq_pend_q <= irq_pend_d;
        end
    end

    assign bus.pad_i    = filt_q;
    assign bus.irq_pend = irq_pend_q;
    assign bus.irq      = |irq_pend_q;

endmodule
`default_nettype wire
